// File: rtl/bcd_scan_counter.sv
// Four-digit packed-BCD up/down counter with load clamping, wrap pulse and a
// time-multiplexed digit scanner feeding a 7-segment decoder.
module bcd_scan_counter #(
    parameter int SCAN_DIV = 1000,
    parameter int LZB      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        wrap,
    output logic [3:0]  bcd,
    output logic [3:0]  dig_sel,
    output logic [1:0]  scan_idx
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] prescaler;
    logic [15:0] count_step;
    logic        step_roll;
    logic        carry;
    logic [3:0]  digit;
    logic        upper_zero;

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Carry/borrow ripples from digit 0 upward; a carry out of digit 3 is a wrap.
    always_comb begin
        count_step = count;
        carry      = 1'b1;
        digit      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            digit = count[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (digit >= 4'd9) count_step[4*i +: 4] = 4'd0;
                    else begin
                        count_step[4*i +: 4] = digit + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) count_step[4*i +: 4] = 4'd9;
                    else begin
                        count_step[4*i +: 4] = digit - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        step_roll = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= clamp_bcd(load_val);
            wrap  <= 1'b0;
        end else if (en) begin
            count <= count_step;
            wrap  <= step_roll;
        end else begin
            wrap  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            scan_idx  <= '0;
        end else if (prescaler == PRESC_LAST) begin
            prescaler <= '0;
            scan_idx  <= scan_idx + 2'd1;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    always_comb begin
        bcd        = count[{scan_idx, 2'b00} +: 4];
        upper_zero = (count >> {scan_idx, 2'b00}) == 16'h0000;
        dig_sel    = ~(4'b0001 << scan_idx);
        if (LZB != 0 && scan_idx != 2'd0 && upper_zero) dig_sel = '1;
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: directed stimulus pushes expected state, a negedge monitor
// pops and compares against two instances (SCAN_DIV=3/LZB=0 and SCAN_DIV=1/LZB=1).
module tb_bcd_scan_counter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;

    logic [15:0] a_count, b_count;
    logic        a_wrap, b_wrap;
    logic [3:0]  a_bcd, b_bcd;
    logic [3:0]  a_dig_sel, b_dig_sel;
    logic [1:0]  a_scan_idx, b_scan_idx;

    bcd_scan_counter #(.SCAN_DIV(3), .LZB(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(a_count), .wrap(a_wrap), .bcd(a_bcd), .dig_sel(a_dig_sel),
        .scan_idx(a_scan_idx)
    );

    bcd_scan_counter #(.SCAN_DIV(1), .LZB(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(b_count), .wrap(b_wrap), .bcd(b_bcd), .dig_sel(b_dig_sel),
        .scan_idx(b_scan_idx)
    );

    typedef struct {
        string       name;
        logic [15:0] cnt;
        logic        wr;
        logic [1:0]  a_idx;
        logic [1:0]  b_idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   k      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] nib(input logic [15:0] c, input logic [1:0] idx);
        case (idx)
            2'd0:    return c[3:0];
            2'd1:    return c[7:4];
            2'd2:    return c[11:8];
            default: return c[15:12];
        endcase
    endfunction

    function automatic logic [3:0] sel(input logic [15:0] c, input logic [1:0] idx, input bit lzb);
        logic [3:0] s;
        logic       blank;
        case (idx)
            2'd0:    begin s = 4'b1110; blank = 1'b0; end
            2'd1:    begin s = 4'b1101; blank = (c[15:4] == 12'h000); end
            2'd2:    begin s = 4'b1011; blank = (c[15:8] == 8'h00); end
            default: begin s = 4'b0111; blank = (c[15:12] == 4'h0); end
        endcase
        return (lzb && blank) ? 4'b1111 : s;
    endfunction

    task automatic chk(input string name, input string what, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", name, what, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then record the state expected after that edge.
    task automatic step(input string name, input logic r, input logic e, input logic u,
                        input logic l, input logic [15:0] lv,
                        input logic [15:0] exp_cnt, input logic exp_wr);
        exp_t x;
        rst = r; en = e; up = u; load = l; load_val = lv;
        @(posedge clk);
        #1;
        if (r) k = 0;
        else k++;
        x.name  = name;
        x.cnt   = exp_cnt;
        x.wr    = exp_wr;
        x.a_idx = 2'((k / 3) % 4);
        x.b_idx = 2'(k % 4);
        sb.push_back(x);
    endtask

    task automatic hold(input string name, input int n, input logic [15:0] exp_cnt);
        for (int i = 0; i < n; i++) step(name, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, exp_cnt, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "a_count",   a_count,           e.cnt);
                chk(e.name, "a_wrap",    16'(a_wrap),       16'(e.wr));
                chk(e.name, "a_idx",     16'(a_scan_idx),   16'(e.a_idx));
                chk(e.name, "a_bcd",     16'(a_bcd),        16'(nib(e.cnt, e.a_idx)));
                chk(e.name, "a_dig_sel", 16'(a_dig_sel),    16'(sel(e.cnt, e.a_idx, 1'b0)));
                chk(e.name, "b_count",   b_count,           e.cnt);
                chk(e.name, "b_wrap",    16'(b_wrap),       16'(e.wr));
                chk(e.name, "b_idx",     16'(b_scan_idx),   16'(e.b_idx));
                chk(e.name, "b_bcd",     16'(b_bcd),        16'(nib(e.cnt, e.b_idx)));
                chk(e.name, "b_dig_sel", 16'(b_dig_sel),    16'(sel(e.cnt, e.b_idx, 1'b1)));
            end
        end
    end

    initial begin : stimulus
        int waited;
        rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h1234;

        step("reset0",  1, 1, 1, 1, 16'h1234, 16'h0000, 0);
        step("reset1",  1, 1, 1, 1, 16'h1234, 16'h0000, 0);
        step("release", 0, 0, 1, 0, 16'h0000, 16'h0000, 0);

        step("ld0999",  0, 0, 1, 1, 16'h0999, 16'h0999, 0);
        step("up_carry",0, 1, 1, 0, 16'h0000, 16'h1000, 0);
        step("ld2009",  0, 0, 1, 1, 16'h2009, 16'h2009, 0);
        step("up_2010", 0, 1, 1, 0, 16'h0000, 16'h2010, 0);
        step("ld9998",  0, 0, 1, 1, 16'h9998, 16'h9998, 0);
        step("up_9999", 0, 1, 1, 0, 16'h0000, 16'h9999, 0);
        step("up_wrap", 0, 1, 1, 0, 16'h0000, 16'h0000, 1);
        step("wrap_off",0, 0, 1, 0, 16'h0000, 16'h0000, 0);

        step("ld1000",  0, 0, 0, 1, 16'h1000, 16'h1000, 0);
        step("dn_borrow",0,1, 0, 0, 16'h0000, 16'h0999, 0);
        step("ld0100",  0, 0, 0, 1, 16'h0100, 16'h0100, 0);
        step("dn_0099", 0, 1, 0, 0, 16'h0000, 16'h0099, 0);
        step("up_0100", 0, 1, 1, 0, 16'h0000, 16'h0100, 0);
        step("ld0000",  0, 0, 0, 1, 16'h0000, 16'h0000, 0);
        step("dn_wrap", 0, 1, 0, 0, 16'h0000, 16'h9999, 1);
        step("hold9999",0, 0, 0, 0, 16'h0000, 16'h9999, 0);

        step("ld_clamp",0, 1, 1, 1, 16'h1A3F, 16'h1939, 0);
        step("ld_ff",   0, 1, 0, 1, 16'hFFFF, 16'h9999, 0);
        step("rst_mid", 1, 1, 1, 0, 16'h0000, 16'h0000, 0);

        step("ld4321",  0, 0, 1, 1, 16'h4321, 16'h4321, 0);
        hold("scan4321", 14, 16'h4321);

        step("ld0042",  0, 0, 1, 1, 16'h0042, 16'h0042, 0);
        hold("blank0042", 8, 16'h0042);
        step("ld0000b", 0, 0, 1, 1, 16'h0000, 16'h0000, 0);
        hold("blank0000", 5, 16'h0000);

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- 4-digit BCD up/down counter with a time-multiplexed display scanner.
- Sits directly upstream of bcd_to_7seg_decoder. Presents one digit's BCD nibble per scan slot on `bcd`, plus an active-low digit strobe for the common-anode/cathode driver.
- Output `bcd` is wired straight into the decoder's 4-bit input. The decoder's 7-bit segment output and `dig_sel` together drive a 4-digit display.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit slot is held; legal range 1..65535.
- LZB, 0: leading-zero blanking enable. 1 = blank leading zero digits; 0 = show all digits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one count step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load of load_val.
- load_val  input  16  four packed BCD digits; [3:0] = digit 0 (least significant).
- count  output  16  registered packed-BCD count value.
- wrap  output  1  one-cycle pulse on 9999->0000 (up) or 0000->9999 (down).
- bcd  output  4  BCD nibble of the currently scanned digit; feeds the decoder.
- dig_sel  output  4  active-low digit strobe; bit i low = digit i lit.
- scan_idx  output  2  index of the currently scanned digit.

Behaviour:
- **Reset** (rst high at clock edge), all other inputs ignored:
  - count=16'h0000, wrap=0, scan_idx=0, prescaler=0.
  - bcd=4'h0, dig_sel=4'b1110.
- **Priority:** rst > load > en.
- **Load:**
  - count <= load_val on the next edge.
  - Any nibble >9 is loaded as 9 (e.g. 16'h1A3F -> 16'h1939).
  - wrap=0 on a load cycle.
- **Counting:**
  - en=1, load=0: count updates on the same edge (1-cycle latency from en sampled to new count).
  - Up: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit; ripple is resolved within one cycle.
  - Down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - Up from 9999 -> 0000 with wrap=1 for exactly that cycle.
  - Down from 0000 -> 9999 with wrap=1 for exactly that cycle.
  - wrap is registered, so it is asserted in the same cycle the wrapped count value appears.
  - en=0: count holds, wrap=0.
  - up may change on any cycle; each step uses up as sampled at that edge.
- **Scanner:**
  - Free-running prescaler counts 0..SCAN_DIV-1. It is independent of en and load, and is cleared only by rst.
  - When the prescaler equals SCAN_DIV-1, it returns to 0 and scan_idx advances 0->1->2->3->0.
  - SCAN_DIV=1: scan_idx advances every cycle.
  - From reset, the first scan_idx change occurs SCAN_DIV cycles after rst deasserts.
- **Digit outputs:**
  - bcd = count[4*scan_idx+3 : 4*scan_idx], combinational from registered count and scan_idx.
  - bcd therefore reflects a count or load change in the same cycle count changes.
  - dig_sel is the one-cold decode of scan_idx: 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
- **Blanking:**
  - LZB=1: digit i (i=1..3) is blanked when it and all higher digits are 0. Blanked means dig_sel=4'b1111 for that slot; bcd still shows the nibble.
  - Digit 0 is never blanked.
  - LZB=0: no blanking.
- **Reset mid-count or mid-scan:** all state returns to reset values on that edge. No partial carry and no wrap pulse are produced.
- **Simultaneous load and en:** load wins; no count step is taken that cycle.

Test Plan:
- Reset: hold rst 2 cycles with en=1, load=1 -> count=0000, wrap=0, scan_idx=0, dig_sel=1110, bcd=0 throughout and after release.
- Up carry and wrap: load 0999, en=1, up=1 for 1 cycle -> 1000. Then load 9998, en for 2 cycles -> 9999, then 0000 with wrap=1 for that cycle only.
- Down borrow and wrap: load 1000, up=0, en 1 cycle -> 0999. Load 0000, en 1 cycle -> 9999 with wrap=1.
- Load clamp and priority: load_val=16'h1A3F with en=1 -> count=1939 on next edge, no step taken, wrap=0.
- Scan with SCAN_DIV=3, count=4321:
  - scan_idx holds each value 3 cycles, sequence 0,1,2,3,0.
  - bcd = 1,2,3,4,1.
  - dig_sel = 1110, 1101, 1011, 0111, 1110.
- Blanking with LZB=1, count=0042, SCAN_DIV=1:
  - Slots 2 and 3 give dig_sel=1111; slots 0 and 1 lit.
  - count=0000: only slot 0 lit, with bcd=0.
